// File: rtl/inst_mem_loader.sv
// Synchronous-read instruction memory with a byte-stream program loader.
// Optional feature macro: IMEM_CHECKSUM_EN (running XOR of all loaded words).
//
// state | meaning
// IDLE  | fetches served, waiting for load_start
// LOAD  | assembling bytes into words and writing them from word 0
// DONE  | one-cycle load_done pulse, then back to IDLE
module inst_mem_loader #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 256,
  localparam int ADDR_W = $clog2(DEPTH),
  localparam int BYTES = WIDTH / 8,
  localparam int OFS_W = $clog2(BYTES)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              fetch_req,
  input  logic [31:0]       pc,
  output logic              fetch_valid,
  output logic [WIDTH-1:0]  instr,
  output logic              fetch_fault,
  input  logic              load_start,
  input  logic [ADDR_W:0]   load_words,
  input  logic              load_byte_valid,
  input  logic [7:0]        load_byte,
  output logic              load_byte_ready,
  output logic              load_done,
  output logic              busy,
  output logic [WIDTH-1:0]  load_checksum
);

  localparam logic [WIDTH-1:0] NOP = WIDTH'(32'h0000_0013);
  localparam logic [32:0] PC_LIMIT = 33'(DEPTH * BYTES);

  typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;

  state_t             state, state_next;
  logic [ADDR_W-1:0]  word_addr;
  logic [ADDR_W:0]    words_q;
  logic [OFS_W-1:0]   byte_idx;
  logic [WIDTH-1:0]   asm_word, wr_word;
  logic [WIDTH-1:0]   mem [DEPTH];
  logic               start_ok, byte_accept, word_write, last_word;
  logic               fetch_accept, fault;
  logic [ADDR_W-1:0]  index;

  assign start_ok    = (state == IDLE) && load_start && (load_words != '0)
                       && (load_words <= (ADDR_W+1)'(DEPTH));
  assign byte_accept = load_byte_valid && load_byte_ready;
  assign word_write  = byte_accept && (byte_idx == OFS_W'(BYTES - 1));
  assign last_word   = ((ADDR_W+1)'(word_addr) + 1'b1) == words_q;

  assign fetch_accept = (state == IDLE) && fetch_req;
  assign index        = pc[OFS_W+ADDR_W-1:OFS_W];
  assign fault        = (pc[OFS_W-1:0] != '0) || ({1'b0, pc} >= PC_LIMIT);

  // The word being written includes the byte arriving this cycle.
  always_comb begin
    wr_word = asm_word;
    wr_word[{byte_idx, 3'b000} +: 8] = load_byte;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next      = state;
    busy            = 1'b0;
    load_byte_ready = 1'b0;
    load_done       = 1'b0;
    case (state)
      IDLE: if (start_ok) state_next = LOAD;
      LOAD: begin
        busy            = 1'b1;
        load_byte_ready = 1'b1;
        if (word_write && last_word) state_next = DONE;
      end
      DONE: begin
        busy       = 1'b1;
        load_done  = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      word_addr   <= '0;
      words_q     <= '0;
      byte_idx    <= '0;
      asm_word    <= '0;
      fetch_valid <= 1'b0;
      fetch_fault <= 1'b0;
      instr       <= '0;
    end else begin
      if (start_ok) begin
        word_addr <= '0;
        byte_idx  <= '0;
        words_q   <= load_words;
      end else if (byte_accept) begin
        asm_word <= wr_word;
        if (word_write) begin
          byte_idx  <= '0;
          word_addr <= word_addr + 1'b1;
        end else begin
          byte_idx <= byte_idx + 1'b1;
        end
      end
      fetch_valid <= fetch_accept;
      if (fetch_accept) begin
        fetch_fault <= fault;
        instr       <= fault ? NOP : mem[index];
      end
    end
  end

  // Memory has no reset so it can map onto block RAM.
  always_ff @(posedge clk) begin
    if (word_write) mem[word_addr] <= wr_word;
  end

`ifdef IMEM_CHECKSUM_EN
  logic [WIDTH-1:0] csum;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)          csum <= '0;
    else if (start_ok)   csum <= '0;
    else if (word_write) csum <= csum ^ wr_word;
  end
  assign load_checksum = csum;
`else
  assign load_checksum = '0;
`endif

endmodule

// File: tb/tb_inst_mem_loader.sv
// Directed bench for inst_mem_loader: fetch vector table plus hand-written
// load sequences (gaps, ignored starts, mid-load reset, fetch/load overlap).
module tb_inst_mem_loader;

  logic        clk = 1'b0;
  logic        reset;
  logic        fetch_req;
  logic [31:0] pc;
  logic        fetch_valid;
  logic [31:0] instr;
  logic        fetch_fault;
  logic        load_start;
  logic [8:0]  load_words;
  logic        load_byte_valid;
  logic [7:0]  load_byte;
  logic        load_byte_ready;
  logic        load_done;
  logic        busy;
  logic [31:0] load_checksum;

  int passed = 0;
  int total  = 0;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        fault;
  } fvec_t;

  fvec_t fv[6];

  inst_mem_loader dut (
    .clk(clk), .reset(reset), .fetch_req(fetch_req), .pc(pc),
    .fetch_valid(fetch_valid), .instr(instr), .fetch_fault(fetch_fault),
    .load_start(load_start), .load_words(load_words),
    .load_byte_valid(load_byte_valid), .load_byte(load_byte),
    .load_byte_ready(load_byte_ready), .load_done(load_done),
    .busy(busy), .load_checksum(load_checksum)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_load(input logic [8:0] n);
    load_start = 1'b1;
    load_words = n;
    tick();
    load_start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    load_byte_valid = 1'b1;
    load_byte       = b;
    tick();
    load_byte_valid = 1'b0;
  endtask

  task automatic fetch_check(input string tag, input logic [31:0] a,
                             input logic [31:0] exp_instr, input logic exp_fault);
    fetch_req = 1'b1;
    pc        = a;
    tick();
    fetch_req = 1'b0;
    chk({tag, " valid"}, 32'(fetch_valid), 32'd1);
    chk({tag, " instr"}, instr, exp_instr);
    chk({tag, " fault"}, 32'(fetch_fault), 32'(exp_fault));
    tick();
    chk({tag, " valid_low"}, 32'(fetch_valid), 32'd0);
    chk({tag, " instr_hold"}, instr, exp_instr);
  endtask

  function automatic logic [31:0] cs_exp(input logic [31:0] v);
`ifdef IMEM_CHECKSUM_EN
    return v;
`else
    return 32'h0 & v;
`endif
  endfunction

  initial begin
    fv[0] = '{pc: 32'h0000_0004, instr: 32'h0010_0093, fault: 1'b0};
    fv[1] = '{pc: 32'h0000_0000, instr: 32'h0000_0013, fault: 1'b0};
    fv[2] = '{pc: 32'h0000_0002, instr: 32'h0000_0013, fault: 1'b1};
    fv[3] = '{pc: 32'h0000_0400, instr: 32'h0000_0013, fault: 1'b1};
    fv[4] = '{pc: 32'h0000_0401, instr: 32'h0000_0013, fault: 1'b1};
    fv[5] = '{pc: 32'hFFFF_FFFC, instr: 32'h0000_0013, fault: 1'b1};

    reset = 1'b0; fetch_req = 1'b0; pc = '0; load_start = 1'b0;
    load_words = '0; load_byte_valid = 1'b0; load_byte = '0;
    #12;
    chk("rst fetch_valid", 32'(fetch_valid), 32'd0);
    chk("rst fetch_fault", 32'(fetch_fault), 32'd0);
    chk("rst instr", instr, 32'd0);
    chk("rst busy", 32'(busy), 32'd0);
    chk("rst ready", 32'(load_byte_ready), 32'd0);
    chk("rst done", 32'(load_done), 32'd0);
    chk("rst checksum", load_checksum, 32'd0);
    tick();
    reset = 1'b1;
    tick();

    // Two-word load with gaps after bytes 2 and 5
    start_load(9'd2);
    chk("l1 busy", 32'(busy), 32'd1);
    chk("l1 ready", 32'(load_byte_ready), 32'd1);
    send_byte(8'h13); send_byte(8'h00); send_byte(8'h00);
    tick();
    send_byte(8'h00); send_byte(8'h93); send_byte(8'h00);
    tick();
    chk("l1 ready in gap", 32'(load_byte_ready), 32'd1);
    send_byte(8'h10);
    chk("l1 no early done", 32'(load_done), 32'd0);
    send_byte(8'h00);
    chk("l1 done", 32'(load_done), 32'd1);
    chk("l1 done busy", 32'(busy), 32'd1);
    chk("l1 done ready", 32'(load_byte_ready), 32'd0);
    tick();
    chk("l1 done pulse", 32'(load_done), 32'd0);
    chk("l1 idle busy", 32'(busy), 32'd0);
    chk("l1 checksum", load_checksum, cs_exp(32'h0010_0080));

    for (int i = 0; i < 6; i++)
      fetch_check($sformatf("fv%0d", i), fv[i].pc, fv[i].instr, fv[i].fault);

    // Out-of-range load lengths are ignored
    start_load(9'd0);
    chk("zero busy", 32'(busy), 32'd0);
    tick();
    chk("zero done", 32'(load_done), 32'd0);
    start_load(9'd257);
    chk("over busy", 32'(busy), 32'd0);
    chk("over ready", 32'(load_byte_ready), 32'd0);

    // Fetch held during load and a stray load_start mid-load
    start_load(9'd2);
    fetch_req = 1'b1; pc = 32'h0;
    send_byte(8'h01); send_byte(8'h02); send_byte(8'h03);
    chk("blk fetch_valid", 32'(fetch_valid), 32'd0);
    chk("blk busy", 32'(busy), 32'd1);
    load_start = 1'b1; load_words = 9'd1;
    send_byte(8'h04);
    load_start = 1'b0;
    chk("blk no done", 32'(load_done), 32'd0);
    send_byte(8'h05); send_byte(8'h06); send_byte(8'h07);
    send_byte(8'h08);
    chk("blk done", 32'(load_done), 32'd1);
    chk("blk fetch dropped", 32'(fetch_valid), 32'd0);
    fetch_req = 1'b0;
    tick();
    chk("blk fetch after done", 32'(fetch_valid), 32'd0);
    chk("blk checksum", load_checksum, cs_exp(32'h0C04_0404));
    fetch_check("blk w0", 32'h0, 32'h0403_0201, 1'b0);
    fetch_check("blk w1", 32'h4, 32'h0807_0605, 1'b0);

    // Fetch and load_start together: fetch sees pre-load contents
    fetch_req = 1'b1; pc = 32'h4;
    start_load(9'd1);
    fetch_req = 1'b0;
    chk("sim fetch_valid", 32'(fetch_valid), 32'd1);
    chk("sim instr", instr, 32'h0807_0605);
    chk("sim busy", 32'(busy), 32'd1);

    // Reset after three bytes
    send_byte(8'h11); send_byte(8'h22); send_byte(8'h33);
    reset = 1'b0;
    #1;
    chk("mrst busy", 32'(busy), 32'd0);
    chk("mrst ready", 32'(load_byte_ready), 32'd0);
    chk("mrst checksum", load_checksum, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    tick();
    start_load(9'd1);
    send_byte(8'hAA); send_byte(8'hBB); send_byte(8'hCC); send_byte(8'hDD);
    chk("nl done", 32'(load_done), 32'd1);
    tick();
    chk("nl checksum", load_checksum, cs_exp(32'hDDCC_BBAA));
    fetch_check("nl w0", 32'h0, 32'hDDCC_BBAA, 1'b0);
    fetch_check("nl w1 kept", 32'h4, 32'h0807_0605, 1'b0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/inst_mem_loader.md
Name: inst_mem_loader

Overview:
- Synchronous-read instruction memory with a built-in byte-stream program loader.
- Successor to the combinational instruction memory: parametrised width and depth, byte-addressed PC, registered fetch with valid and fault flags.
- A loader FSM assembles incoming bytes into words and writes them sequentially from word 0.
- Sits between the fetch stage (PC in, instruction out) and a host or boot interface (byte stream in).

Parameters:
- WIDTH, 32, instruction word width in bits; must be a multiple of 8.
- DEPTH, 256, number of words.
- ADDR_W, $clog2(DEPTH), word-index width; derived, not overridden.
- BYTES, WIDTH/8, bytes per word; derived.
- OFS_W, $clog2(BYTES), PC byte-offset width; derived.

Ports:
- clk  input  1  clock, rising edge
- reset  input  1  asynchronous, active-low reset
- fetch_req  input  1  fetch request
- pc  input  32  byte address of the instruction
- fetch_valid  output  1  instr and fetch_fault are valid
- instr  output  WIDTH  fetched instruction
- fetch_fault  output  1  misaligned or out-of-range pc
- load_start  input  1  begin a load; sampled in IDLE only
- load_words  input  ADDR_W+1  number of words to load, range 1..DEPTH
- load_byte_valid  input  1  load_byte is valid
- load_byte  input  8  program byte, little-endian within each word
- load_byte_ready  output  1  loader accepts a byte this cycle
- load_done  output  1  one-cycle pulse when the load completes
- busy  output  1  loader active; fetches are blocked
- load_checksum  output  WIDTH  XOR of all words written (see Optional Feature)

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE; fetch_valid, fetch_fault, load_byte_ready, load_done and busy all 0; instr=0; load_checksum=0.
  - Internal word_addr, byte_idx and assembly register cleared.
  - Memory array is NOT cleared; contents are retained but undefined after power-up.
- FSM states: IDLE, LOAD, DONE.
- IDLE:
  - load_start=1 with 1<=load_words<=DEPTH: capture load_words and go to LOAD; word_addr=0, byte_idx=0.
  - load_start with load_words=0 or >DEPTH: ignored; stay in IDLE with no pulse.
- LOAD:
  - busy=1, load_byte_ready=1.
  - A byte is accepted when load_byte_valid && load_byte_ready.
  - An accepted byte goes to lane byte_idx of the assembly register, and byte_idx increments.
  - On the byte with byte_idx=BYTES-1, the completed word (including that byte) is written to mem[word_addr] on the same edge. byte_idx then returns to 0 and word_addr increments.
  - Gaps in load_byte_valid are allowed; no timeout.
  - Go to DONE on the edge that writes word number load_words-1.
- DONE:
  - busy=1, load_byte_ready=0, load_done=1 for exactly one cycle.
  - Go to IDLE on the next edge.
- load_start in LOAD or DONE is ignored.
- Fetch:
  - Accepted only when state=IDLE and fetch_req=1. Latency is 1 cycle: fetch_valid=1 on the following cycle and low otherwise.
  - index = pc[OFS_W+ADDR_W-1:OFS_W].
  - fetch_fault=1 if pc[OFS_W-1:0]!=0 or pc>=DEPTH*BYTES.
  - On a fault, instr = 32'h0000_0013 (NOP), zero-extended or truncated to WIDTH. Otherwise instr = mem[index].
  - When fetch_valid=0, instr and fetch_fault hold their last values.
  - fetch_req outside IDLE is dropped (not queued); the fetch stage must stall while busy=1.
- Simultaneous events:
  - fetch_req and a valid load_start in the same IDLE cycle: both are accepted. The fetch returns pre-load contents, and LOAD starts.
  - The write and the read path never conflict, because fetches are blocked during LOAD.
- Reset mid-load: the FSM returns to IDLE immediately. Words already written remain in memory, and a partially assembled word is discarded. The next load restarts at word 0.

Optional Feature:
- Macro: IMEM_CHECKSUM_EN.
- Defined:
  - load_checksum is cleared when a load is accepted in IDLE.
  - Every word written is XORed into load_checksum on the same edge as the write.
  - The value is stable from the load_done cycle until the next accepted load_start or reset.
- Undefined: load_checksum is tied to 0, and no checksum register is synthesised.

Test Plan:
- Load load_words=2 with bytes 13 00 00 00 93 00 10 00 (gaps inserted after bytes 2 and 5) -> mem[0]=0x00000013, mem[1]=0x00100093; load_done pulses one cycle after the 8th byte is accepted; busy falls with DONE -> IDLE.
- After the load, fetch_req with pc=0x4 -> next cycle fetch_valid=1, instr=0x00100093, fetch_fault=0; with pc=0x0 -> instr=0x00000013.
- pc=0x2 (misaligned) and pc=0x400 (out of range at DEPTH=256) -> fetch_valid=1, fetch_fault=1, instr=0x00000013.
- fetch_req held high during LOAD -> fetch_valid stays 0, busy=1; load_start pulsed mid-load -> no effect on word_addr; load_words=0 -> stays IDLE, no load_done.
- reset driven low after 3 bytes of a load -> IDLE, load_byte_ready=0, busy=0; a new 1-word load of AA BB CC DD -> mem[0]=0xDDCCBBAA.
- With IMEM_CHECKSUM_EN, after the 2-word load above -> load_checksum=0x00100080. Without the macro -> load_checksum=0 throughout.
